// File: rtl/cnn_avgp_border_norm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_avgp_border_norm_pkg
// Description : Shared definitions for the average-pooling border
//               normalisation stage: position-class encodings and a counter
//               width helper used by the position counter.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_avgp_border_norm_pkg;

    // Position class of a pixel inside a zero-padded 3x3 window plane
    localparam logic [1:0] CLS_INTERIOR = 2'd0;
    localparam logic [1:0] CLS_EDGE     = 2'd1;
    localparam logic [1:0] CLS_CORNER   = 2'd2;

    // Counter width for a range of n positions ($clog2(n)), never below 1
    // bit so that a single-channel build still gets a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : cnn_avgp_border_norm_pkg
`default_nettype wire

// File: rtl/cnn_avgp_border_norm_pos_counter.sv
`default_nettype none
// ============================================================================
// Module      : avgp_pos_counter
// Description : Column/row/channel position tracker for a channel-planar
//               raster stream. Classifies the pixel currently presented on
//               i_valid as interior, edge or corner of its plane and flags the
//               last pixel of the last channel. Reusable by any padded-window
//               stage.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset
//               i_valid - current pixel qualifier, advances the counters
//               o_cls   - class of the current pixel (CLS_* encoding)
//               o_last  - current pixel is (ch=C-1, row=H-1, col=W-1)
// Revision    : 1.0 - initial release
// ============================================================================
module avgp_pos_counter
    import cnn_avgp_border_norm_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 16,
    parameter int IMAGE_HEIGHT = 16,
    parameter int CHANNEL_NUM  = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    output logic [1:0] o_cls,
    output logic       o_last
);

    localparam int c_col_w = cnt_width(IMAGE_WIDTH);
    localparam int c_row_w = cnt_width(IMAGE_HEIGHT);
    localparam int c_ch_w  = cnt_width(CHANNEL_NUM);

    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMAGE_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMAGE_HEIGHT - 1);
    localparam logic [c_ch_w-1:0]  c_ch_last  = c_ch_w'(CHANNEL_NUM - 1);

    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic [c_ch_w-1:0]  r_ch;

    logic w_col_wrap;
    logic w_row_wrap;
    logic w_ch_wrap;
    logic w_row_edge;
    logic w_col_edge;

    assign w_col_wrap = (r_col == c_col_last);
    assign w_row_wrap = (r_row == c_row_last);
    assign w_ch_wrap  = (r_ch  == c_ch_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
            r_ch  <= '0;
        end else if (i_valid) begin
            if (w_col_wrap) begin
                r_col <= '0;
                if (w_row_wrap) begin
                    r_row <= '0;
                    // Frames run back to back: the channel counter simply
                    // wraps and the next pixel is (ch0,row0,col0).
                    r_ch  <= w_ch_wrap ? '0 : r_ch + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Classification uses the counter values before this pixel's increment
    assign w_row_edge = (r_row == '0) || w_row_wrap;
    assign w_col_edge = (r_col == '0) || w_col_wrap;

    always_comb begin
        o_cls = CLS_INTERIOR;
        if (w_row_edge && w_col_edge) begin
            o_cls = CLS_CORNER;
        end else if (w_row_edge || w_col_edge) begin
            o_cls = CLS_EDGE;
        end
    end

    assign o_last = w_col_wrap && w_row_wrap && w_ch_wrap;

endmodule : avgp_pos_counter
`default_nettype wire

// File: rtl/cnn_avgp_border_norm.sv
`default_nettype none
// ============================================================================
// Module      : cnn_avgp_border_norm
// Description : Border normalisation after a zero-padded 3x3 stride-1 average
//               pool. The incoming value is sum/9 everywhere; edges are
//               rescaled by 9/6 and corners by 9/4 so each output is the mean
//               of in-image pixels only. Shift-add only, 2-cycle latency,
//               1 pixel/cycle, no backpressure.
// Ports       : clk        - clock, rising edge
//               reset      - synchronous active-high reset
//               valid_in   - pxl_in qualifier (gaps allowed)
//               pxl_in     - zero-padded 3x3 average
//               pxl_out    - border-normalised average (held when idle)
//               valid_out  - pxl_out qualifier
//               frame_done - pulse with valid_out of the frame's last pixel
// Options     : AVGP_NORM_SAT_EN - when defined, results saturate to the
//               signed DATA_WIDTH range; otherwise they wrap (truncate).
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_avgp_border_norm
    import cnn_avgp_border_norm_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 8,
    parameter int IMAGE_WIDTH  = 16,
    parameter int IMAGE_HEIGHT = 16,
    parameter int CHANNEL_NUM  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    // Elaboration-time sanity: the border classes need at least two rows and
    // columns, and the fixed-point format must leave room for the sign.
    if (IMAGE_WIDTH < 2 || IMAGE_HEIGHT < 2 || FRAC_BITS >= DATA_WIDTH) begin : g_param_chk
        $error("cnn_avgp_border_norm: illegal parameter combination");
    end

`ifdef AVGP_NORM_SAT_EN
    // Worst case is a corner: 2.25 * full scale needs two guard bits
    localparam int c_ext_w = DATA_WIDTH + 2;
`else
    // Wrapping result only needs the low bits; shift-add modulo 2^DW gives
    // exactly the same low bits as the extended computation.
    localparam int c_ext_w = DATA_WIDTH;
`endif

    // ------------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------------
    logic [1:0] w_cls;
    logic       w_last;

    avgp_pos_counter #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .CHANNEL_NUM  (CHANNEL_NUM)
    ) u_pos_counter (
        .clk     (clk),
        .rst     (reset),
        .i_valid (valid_in),
        .o_cls   (w_cls),
        .o_last  (w_last)
    );

    // ------------------------------------------------------------------------
    // Stage 1: capture pixel, class and last flag
    // ------------------------------------------------------------------------
    logic                         r_s1_valid;
    logic signed [DATA_WIDTH-1:0] r_s1_pxl;
    logic [1:0]                   r_s1_cls;
    logic                         r_s1_last;

    // ------------------------------------------------------------------------
    // Stage 2 arithmetic: y = x, x + x/2, or 2x + x/4 (floor shifts)
    // ------------------------------------------------------------------------
    logic signed [c_ext_w-1:0]    w_x;
    logic signed [c_ext_w-1:0]    w_half;
    logic signed [c_ext_w-1:0]    w_quarter;
    logic signed [c_ext_w-1:0]    w_y;
    logic [DATA_WIDTH-1:0]        w_res;

    assign w_x       = c_ext_w'(r_s1_pxl);
    assign w_half    = w_x >>> 1;
    assign w_quarter = w_x >>> 2;

    always_comb begin
        w_y = w_x;
        case (r_s1_cls)
            CLS_EDGE:   w_y = w_x + w_half;
            CLS_CORNER: w_y = (w_x <<< 1) + w_quarter;
            default:    w_y = w_x;
        endcase
    end

`ifdef AVGP_NORM_SAT_EN
    localparam logic signed [c_ext_w-1:0] c_sat_max = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [c_ext_w-1:0] c_sat_min = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        w_res = w_y[DATA_WIDTH-1:0];
        if (w_y > c_sat_max) begin
            w_res = c_sat_max[DATA_WIDTH-1:0];
        end else if (w_y < c_sat_min) begin
            w_res = c_sat_min[DATA_WIDTH-1:0];
        end
    end
`else
    assign w_res = w_y;
`endif

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_pxl_out;
    logic                  r_valid_out;
    logic                  r_frame_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_pxl     <= '0;
            r_s1_cls     <= CLS_INTERIOR;
            r_s1_last    <= 1'b0;
            r_pxl_out    <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_pxl  <= $signed(pxl_in);
                r_s1_cls  <= w_cls;
                r_s1_last <= w_last;
            end
            r_valid_out  <= r_s1_valid;
            r_frame_done <= r_s1_valid && r_s1_last;
            // Output data is held across idle cycles
            if (r_s1_valid) begin
                r_pxl_out <= w_res;
            end
        end
    end

    assign pxl_out    = r_pxl_out;
    assign valid_out  = r_valid_out;
    assign frame_done = r_frame_done;

endmodule : cnn_avgp_border_norm
`default_nettype wire

// File: tb/tb_cnn_avgp_border_norm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_avgp_border_norm
// Description : Directed self-checking bench for cnn_avgp_border_norm with
//               W=H=4, C=2, DW=16. Each stimulus call supplies hand-computed
//               interior/edge/corner results; the bench tracks pixel position
//               itself and checks value, frame_done and 2-cycle latency of
//               every output, plus idle-cycle hold and reset behaviour.
// Options     : AVGP_NORM_SAT_EN - selects saturating expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_avgp_border_norm;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int C  = 2;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] pxl_in;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
    logic          frame_done;

    cnn_avgp_border_norm #(
        .DATA_WIDTH   (DW),
        .FRAC_BITS    (8),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .CHANNEL_NUM  (C)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .pxl_in     (pxl_in),
        .pxl_out    (pxl_out),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] v;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];

    int       n_checks = 0;
    int       n_errors = 0;
    int       fd_cnt   = 0;
    bit       mon_en   = 1'b0;
    logic [DW-1:0] last_pxl = '0;
    int       b_col = 0;
    int       b_row = 0;
    int       b_ch  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Drive n pixels of constant value x; expected result chosen by the
    // bench's own position tracking from the hand-computed class values.
    task automatic drive_px(input logic [DW-1:0] x, input logic [DW-1:0] e_int,
                            input logic [DW-1:0] e_edge, input logic [DW-1:0] e_corner,
                            input int n, input bit gaps, input bit trail);
        exp_t e;
        bit   re;
        bit   ce;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    valid_in = 1'b0;
                end
            end
            @(posedge clk); #1;
            valid_in = 1'b1;
            pxl_in   = x;
            re = (b_row == 0) || (b_row == H - 1);
            ce = (b_col == 0) || (b_col == W - 1);
            e.v    = (re && ce) ? e_corner : ((re || ce) ? e_edge : e_int);
            e.last = (b_ch == C - 1) && (b_row == H - 1) && (b_col == W - 1);
            e.cyc  = cyc;
            exp_q.push_back(e);
            if (b_col == W - 1) begin
                b_col = 0;
                if (b_row == H - 1) begin
                    b_row = 0;
                    b_ch  = (b_ch == C - 1) ? 0 : b_ch + 1;
                end else begin
                    b_row = b_row + 1;
                end
            end else begin
                b_col = b_col + 1;
            end
        end
        if (trail) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
        end
    endtask

    // Output monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid_out", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pxl_out", 32'(pxl_out), 32'(e.v));
                    chk("frame_done", 32'(frame_done), 32'(e.last));
                    chk("latency", 32'(cyc - e.cyc), 32'd2);
                end
                last_pxl = pxl_out;
                if (frame_done) fd_cnt++;
            end else begin
                chk("frame_done_idle", 32'(frame_done), 32'd0);
                chk("pxl_out_hold", 32'(pxl_out), 32'(last_pxl));
            end
            if (reset) last_pxl = '0;
        end
    end

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        pxl_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_pxl_out", 32'(pxl_out), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // 1.0 everywhere: interior 1.0, edge 1.5, corner 2.25
        drive_px(16'h0100, 16'h0100, 16'h0180, 16'h0240, 32, 1'b0, 1'b1);
        // -1.0 everywhere
        drive_px(16'hFF00, 16'hFF00, 16'hFE80, 16'hFDC0, 32, 1'b0, 1'b1);
        // Odd raw value: 3 + 1 = 4 on edges, 6 + 0 = 6 on corners
        drive_px(16'h0003, 16'h0003, 16'h0004, 16'h0006, 32, 1'b0, 1'b1);
`ifdef AVGP_NORM_SAT_EN
        drive_px(16'h7000, 16'h7000, 16'h7FFF, 16'h7FFF, 32, 1'b0, 1'b1);
        drive_px(16'h9000, 16'h9000, 16'h8000, 16'h8000, 32, 1'b0, 1'b1);
`else
        // 28672: edge 43008 -> 0xA800, corner 64512 -> 0xFC00
        drive_px(16'h7000, 16'h7000, 16'hA800, 16'hFC00, 32, 1'b0, 1'b1);
        // -28672: edge -43008 -> 0x5800, corner -64512 -> 0x0400
        drive_px(16'h9000, 16'h9000, 16'h5800, 16'h0400, 32, 1'b0, 1'b1);
`endif
        // Two frames with random idle gaps
        drive_px(16'h0100, 16'h0100, 16'h0180, 16'h0240, 64, 1'b1, 1'b1);

        // Reset in the middle of a frame
        drive_px(16'h0100, 16'h0100, 16'h0180, 16'h0240, 10, 1'b0, 1'b0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        b_col = 0;
        b_row = 0;
        b_ch  = 0;
        chk("midrst_valid_out", 32'(valid_out), 32'd0);
        chk("midrst_pxl_out", 32'(pxl_out), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        drive_px(16'h0100, 16'h0100, 16'h0180, 16'h0240, 32, 1'b0, 1'b1);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        chk("frame_done_count", 32'(fd_cnt), 32'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cnn_avgp_border_norm
`default_nettype wire
